// File: rtl/multi_key_led_blinker.sv
// N-channel key-driven LED blinker: each key is synchronised, debounced and edge-detected,
// and every press steps its channel through OFF -> BLINK -> ON -> OFF.
module multi_key_led_blinker #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DEB_CYC    = 1_000_000,
  parameter int unsigned PERIOD_CYC = 50_000_000,
  parameter int unsigned DUTY_CYC   = 25_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     key_n,
  output logic [N_CH-1:0]     led,
  output logic [2*N_CH-1:0]   mode_o,
  output logic [N_CH-1:0]     key_pulse
);

  localparam int unsigned DcW = $clog2(DEB_CYC + 1);
  localparam int unsigned PhW = $clog2(PERIOD_CYC);
  localparam logic [DcW-1:0] DcLast = DcW'(DEB_CYC - 1);
  localparam logic [PhW-1:0] PhLast = PhW'(PERIOD_CYC - 1);
  localparam logic [PhW-1:0] PhOne  = PhW'(1);
  localparam logic [DcW-1:0] DcOne  = DcW'(1);

  typedef enum logic [1:0] {
    StOff     = 2'b00,
    StBlink   = 2'b01,
    StOn      = 2'b10,
    StIllegal = 2'b11
  } mode_e;

  if (DUTY_CYC > PERIOD_CYC || DEB_CYC < 1 || PERIOD_CYC < 2) begin : g_bad_params
    $error("multi_key_led_blinker: illegal DEB_CYC/PERIOD_CYC/DUTY_CYC combination");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic           r_sync1, r_sync2, r_kd, r_pulse, r_led;
    logic [DcW-1:0] r_dc;
    logic [PhW-1:0] r_ph, w_ph_next;
    mode_e          r_mode, w_mode_next;
    logic           w_led_next;

    always_comb begin
      w_mode_next = r_mode;
      if (r_mode == StIllegal) begin
        w_mode_next = StOff;
      end else if (r_pulse) begin
        case (r_mode)
          StOff:   w_mode_next = StBlink;
          StBlink: w_mode_next = StOn;
          default: w_mode_next = StOff;
        endcase
      end

      // Phase restarts on BLINK entry so the LED always opens with a full on-window.
      w_ph_next = '0;
      if (w_mode_next == StBlink && r_mode == StBlink) begin
        w_ph_next = (r_ph == PhLast) ? '0 : r_ph + PhOne;
      end

      w_led_next = (w_mode_next == StOn) ||
                   (w_mode_next == StBlink && 32'(w_ph_next) < DUTY_CYC);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
        r_kd    <= 1'b1;
        r_dc    <= '0;
        r_pulse <= 1'b0;
        r_mode  <= StOff;
        r_ph    <= '0;
        r_led   <= 1'b0;
      end else begin
        r_sync1 <= key_n[i];
        r_sync2 <= r_sync1;
        r_pulse <= 1'b0;
        if (r_sync2 == r_kd) begin
          r_dc <= '0;
        end else if (r_dc == DcLast) begin
          r_kd    <= r_sync2;
          r_dc    <= '0;
          r_pulse <= r_kd;  // accepted level was released, so this is a press
        end else begin
          r_dc <= r_dc + DcOne;
        end
        r_mode <= w_mode_next;
        r_ph   <= w_ph_next;
        r_led  <= w_led_next;
      end
    end

    assign led[i]          = r_led;
    assign key_pulse[i]    = r_pulse;
    assign mode_o[2*i +: 2] = r_mode;
  end

endmodule
